alu_wb_stage: RTL and testbench
===============================

// Module: alu_wb_stage
// PURPOSE
//  Execute-to-writeback stage directly downstream of the ALU operation units.
//  - Accepts the packed 20-bit ALU word {C,Z,V,S,result[15:0]} (bit16=S, bit17=V, bit18=Z, bit19=C).
//  - Buffers it in a small FIFO with a valid/ready handshake.
//  - Owns the architectural S/Z/C/V flag register and evaluates branch conditions from it.
// PARAMETERS
//  DW     16  result data width; the packed word is DW+4 bits
//  RW      3  destination register index width
//  DEPTH   2  FIFO entries; power of two, >=2
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  in_valid    in   1      upstream word valid
//  in_ready    out  1      stage can accept; registered, equals (count<DEPTH)
//  in_word     in   DW+4   packed {C,Z,V,S,result}
//  in_rd       in   RW     destination register index
//  in_we       in   1      entry writes the register file
//  in_flag_en  in   1      entry updates the flag register
//  wb_valid    out  1      head entry valid; registered, equals (count!=0)
//  wb_ready    in   1      register file accepts head
//  wb_data     out  DW     head result
//  wb_rd       out  RW     head destination index
//  wb_we       out  1      head write enable; gated: wb_valid & head.we
//  flag_s/z/c/v out 1 each current flag register
//  cond        in   3      branch condition select
//  taken       out  1      condition result; combinational from the flag register only
//  count       out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (async, any time): count=0; rd/wr pointers=0; flags=0; in_ready=1; wb_valid=0.
//   FIFO contents are don't-care. In-flight entries are discarded and no writeback occurs.
//  Handshake:
//   - push = in_valid & in_ready; pop = wb_valid & wb_ready.
//   - in_valid may assert without waiting for in_ready.
//   - The head must stay stable while wb_valid & !wb_ready.
//  Latency: a pushed word appears on wb_* the next cycle when the FIFO was empty.
//   No combinational in->wb path.
//  Count rules:
//   - push only: +1. pop only: -1. Push and pop in the same cycle: unchanged, legal at any count<DEPTH.
//   - Full: in_ready=0; in_valid ignored, no overflow.
//   - Empty: wb_valid=0; wb_ready ignored, no underflow.
//   - Pointers wrap modulo DEPTH.
//  Flags:
//   - On push with in_flag_en=1, {S,V,Z,C} <= in_word[16],[17],[18],[19] in the same edge.
//   - Visible to taken on the next cycle.
//   - Flags update at accept, not at writeback, so branch order matches issue order.
//   - Push with in_flag_en=0, or no push: flags hold.
//  cond encoding:
//   000 Z | 001 S^V | 010 Z|(S^V) | 011 !Z | 100 C | 101 V | 110 1 | 111 0.
//  wb_data = head.word[DW-1:0]. Flag bits are not forwarded to writeback.
//  Entry with in_we=0 (e.g. compare): still occupies a slot and is popped normally, with wb_we=0.
// TESTING
//  1) Reset, then push {C0,Z1,V0,S0,0x0000} with flag_en=1 and wb_ready=1
//     -> next cycle wb_valid=1, wb_data=0x0000, flag_z=1; cond=000 -> taken=1.
//  2) wb_ready=0; push 0x1111, 0x2222, 0x3333 back-to-back
//     -> count=2, in_ready=0 after 2nd; 3rd is held upstream; wb_data stays 0x1111.
//  3) FIFO full, then wb_ready=1 with in_valid=1 continuously
//     -> one pop and one push per cycle once ready; order 0x1111,0x2222,0x3333; no loss or duplicates.
//  4) Push S=1,V=0 with flag_en=1, then push S=0,V=0 with flag_en=0
//     -> flag_s stays 1; cond=001 taken=1; cond=010 taken=1; cond=111 taken=0.
//  5) Assert rst asynchronously mid-cycle with count=2 and flags nonzero
//     -> wb_valid=0, count=0, all flags 0 before the next edge; after release, the first push is returned correctly.
//  6) Push with in_we=0, rd=5
//     -> wb_valid=1, wb_we=0, pop consumes it, count returns to 0.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers packed ALU words in a small FIFO,
// owns the architectural S/Z/C/V flag register and resolves branch conditions.
module alu_wb_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned RW    = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW+3:0]            in_word,
  input  logic [RW-1:0]            in_rd,
  input  logic                     in_we,
  input  logic                     in_flag_en,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DW-1:0]            wb_data,
  output logic [RW-1:0]            wb_rd,
  output logic                     wb_we,
  output logic                     flag_s,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     flag_v,
  input  logic [2:0]               cond,
  output logic                     taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Flag bit positions inside the packed word {C,Z,V,S,result}
  localparam int unsigned S_BIT = DW;
  localparam int unsigned V_BIT = DW + 1;
  localparam int unsigned Z_BIT = DW + 2;
  localparam int unsigned C_BIT = DW + 3;

  logic [DW-1:0] mem_data [DEPTH];
  logic [RW-1:0] mem_rd   [DEPTH];
  logic          mem_we   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // Handshake qualification; in_ready/wb_valid are registered so this is glitch-free
  always_comb begin
    push = in_valid & in_ready;
    pop  = wb_valid & wb_ready;
  end

  // Next occupancy from the push/pop pair
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Occupancy, pointers and the registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
      wb_valid <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt < CW'(DEPTH));
      wb_valid <= (count_nxt != '0);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_word[DW-1:0];
      mem_rd[wr_ptr]   <= in_rd;
      mem_we[wr_ptr]   <= in_we;
    end
  end

  // Flags update at accept time so branch resolution follows issue order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_s <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (push && in_flag_en) begin
      flag_s <= in_word[S_BIT];
      flag_v <= in_word[V_BIT];
      flag_z <= in_word[Z_BIT];
      flag_c <= in_word[C_BIT];
    end
  end

  // Head presentation; write enable is suppressed while the FIFO is empty
  always_comb begin
    wb_data = mem_data[rd_ptr];
    wb_rd   = mem_rd[rd_ptr];
    wb_we   = wb_valid & mem_we[rd_ptr];
  end

  // Branch condition decode from the flag register only
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000: taken = flag_z;
      3'b001: taken = flag_s ^ flag_v;
      3'b010: taken = flag_z | (flag_s ^ flag_v);
      3'b011: taken = ~flag_z;
      3'b100: taken = flag_c;
      3'b101: taken = flag_v;
      3'b110: taken = 1'b1;
      3'b111: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_alu_wb_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_word;
  logic [2:0]  in_rd;
  logic        in_we;
  logic        in_flag_en;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic        flag_s, flag_z, flag_c, flag_v;
  logic [2:0]  cond;
  logic        taken;
  logic [1:0]  count;

  alu_wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_rd(in_rd), .in_we(in_we), .in_flag_en(in_flag_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .cond(cond), .taken(taken), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        we;
  } entry_t;

  entry_t      q[$];
  logic        m_s, m_z, m_c, m_v;
  int          checks;
  int          errors;
  bit          last_push;

  function automatic logic model_taken(input logic [2:0] c);
    int lt;
    lt = (m_s != m_v);
    if (c == 3'd0) return m_z;
    if (c == 3'd1) return logic'(lt);
    if (c == 3'd2) return m_z || (lt != 0);
    if (c == 3'd3) return !m_z;
    if (c == 3'd4) return m_c;
    if (c == 3'd5) return m_v;
    if (c == 3'd6) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_s = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(q.size() != 0));
    check({tag, ".flags"},    32'({flag_s, flag_z, flag_c, flag_v}), 32'({m_s, m_z, m_c, m_v}));
    check({tag, ".taken"},    32'(taken),    32'(model_taken(cond)));
    if (q.size() != 0) begin
      check({tag, ".wb_data"}, 32'(wb_data), 32'(q[0].data));
      check({tag, ".wb_rd"},   32'(wb_rd),   32'(q[0].rd));
      check({tag, ".wb_we"},   32'(wb_we),   32'(q[0].we));
    end else begin
      check({tag, ".wb_we"},   32'(wb_we),   32'(0));
    end
  endtask

  // One clock: model follows the handshake seen at the edge, then outputs are compared
  task automatic step(input string tag);
    bit push_m, pop_m;
    entry_t e;
    @(posedge clk);
    push_m = in_valid && (q.size() < DEPTH);
    pop_m  = wb_ready && (q.size() != 0);
    if (pop_m) void'(q.pop_front());
    if (push_m) begin
      e.data = in_word[15:0];
      e.rd   = in_rd;
      e.we   = in_we;
      q.push_back(e);
      if (in_flag_en) begin
        m_s = in_word[16]; m_v = in_word[17]; m_z = in_word[18]; m_c = in_word[19];
      end
    end
    last_push = push_m;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [19:0] w, input logic [2:0] rd,
                       input logic we, input logic fe, input logic wr, input logic [2:0] c);
    in_valid = v; in_word = w; in_rd = rd; in_we = we; in_flag_en = fe;
    wb_ready = wr; cond = c;
  endtask

  // Sweep every branch condition against the current flag register
  task automatic cond_sweep(input string tag);
    for (int c = 0; c < 8; c++) begin
      cond = 3'(c);
      #1;
      check({tag, ".taken"}, 32'(taken), 32'(model_taken(3'(c))));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    drive(1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_held");
    rst = 1'b0;

    // 1) zero result sets Z; next cycle head is visible
    drive(1'b1, {4'b0100, 16'h0000}, 3'd1, 1'b1, 1'b1, 1'b1, 3'd0);
    step("t1_push");
    check("t1_z", 32'(flag_z), 32'(1));
    check("t1_taken", 32'(taken), 32'(1));
    check("t1_data", 32'(wb_data), 32'h0000);

    // 2) drain, then stall the consumer and push three back-to-back
    drive(1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    step("t2_drain");
    drive(1'b1, 20'h01111, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    step("t2_p1");
    drive(1'b1, 20'h02222, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    step("t2_p2");
    check("t2_full_count", 32'(count), 32'(2));
    check("t2_full_ready", 32'(in_ready), 32'(0));
    drive(1'b1, 20'h03333, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0);
    step("t2_p3_held");
    check("t2_head_stable", 32'(wb_data), 32'h1111);

    // 3) consumer resumes with producer holding 0x3333 until taken
    wb_ready = 1'b1;
    last_push = 1'b0;
    for (int i = 0; i < 4 && !last_push; i++) step("t3_hold");
    check("t3_accepted", 32'(last_push), 32'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("t3_drain");
    check("t3_empty", 32'(count), 32'(0));

    // 4) S=1,V=0 with flag update, then S=0,V=0 without
    drive(1'b1, 20'h1_0005, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1);
    step("t4_a");
    drive(1'b1, 20'h0_0006, 3'd1, 1'b1, 1'b0, 1'b1, 3'd1);
    step("t4_b");
    check("t4_s_hold", 32'(flag_s), 32'(1));
    in_valid = 1'b0;
    cond_sweep("t4_sweep");
    step("t4_drain");

    // 5) async reset mid-cycle with two entries and nonzero flags
    drive(1'b1, 20'hF_1234, 3'd6, 1'b1, 1'b1, 1'b0, 3'd4);
    step("t5_fill1");
    drive(1'b1, 20'h0_5678, 3'd7, 1'b1, 1'b0, 1'b0, 3'd4);
    step("t5_fill2");
    check("t5_pre_count", 32'(count), 32'(2));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("t5_async");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 20'h2_ABCD, 3'd2, 1'b1, 1'b1, 1'b0, 3'd3);
    step("t5_after");
    check("t5_first_data", 32'(wb_data), 32'hABCD);

    // 6) compare-style entry with no register write
    drive(1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    step("t6_drain");
    drive(1'b1, 20'h0_0042, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0);
    step("t6_push");
    check("t6_we", 32'(wb_we), 32'(0));
    check("t6_rd", 32'(wb_rd), 32'(5));
    drive(1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    step("t6_pop");
    check("t6_count", 32'(count), 32'(0));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 20'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
